// File: rtl/updown_counter.sv
// Parametrised synchronous up/down counter with programmable modulus,
// load with clamp, synchronous clear, and wrap-or-saturate boundary handling.
module updown_counter #(
    parameter int unsigned          WIDTH    = 8,
    parameter logic [WIDTH-1:0]     MAX_VAL  = {WIDTH{1'b1}},
    parameter bit                   SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             at_zero,
    output logic             at_max,
    output logic             wrap
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;

    logic             is_zero;
    logic             is_max;

    assign is_zero = (count_q == '0);
    assign is_max  = (count_q == MAX_VAL);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_data > MAX_VAL) ? MAX_VAL : load_data;
        end else if (en) begin
            if (up) begin
                if (is_max) begin
                    wrap_d  = 1'b1;
                    count_d = SATURATE ? MAX_VAL : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (is_zero) begin
                    wrap_d  = 1'b1;
                    count_d = SATURATE ? '0 : MAX_VAL;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    // Reset is sampled on the clock edge, so it also suppresses a same-edge wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count   = count_q;
    assign wrap    = wrap_q;
    assign at_zero = is_zero;
    assign at_max  = is_max;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench: three counter configurations share one stimulus stream and are
// checked against hand-computed values.
module tb_updown_counter;

    logic       clk;
    logic       reset_n;
    logic       clear;
    logic       load;
    logic [7:0] load_data;
    logic       en;
    logic       up;

    logic [3:0] a_count, s_count;
    logic [7:0] f_count;
    logic       a_zero, a_max, a_wrap;
    logic       s_zero, s_max, s_wrap;
    logic       f_zero, f_max, f_wrap;

    int tests_run;
    int tests_failed;

    updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
        .load_data(load_data[3:0]), .en(en), .up(up),
        .count(a_count), .at_zero(a_zero), .at_max(a_max), .wrap(a_wrap)
    );

    updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
        .load_data(load_data[3:0]), .en(en), .up(up),
        .count(s_count), .at_zero(s_zero), .at_max(s_max), .wrap(s_wrap)
    );

    updown_counter #(.WIDTH(8)) u_full (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
        .load_data(load_data), .en(en), .up(up),
        .count(f_count), .at_zero(f_zero), .at_max(f_max), .wrap(f_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle outputs before checking.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        reset_n   = 1'b0;
        clear     = 1'b0;
        load      = 1'b1;
        load_data = 8'd5;
        en        = 1'b1;
        up        = 1'b1;
        step();
        step();
        chk("rst_count", a_count, 0);
        chk("rst_zero",  a_zero,  1);
        chk("rst_max",   a_max,   0);
        chk("rst_wrap",  a_wrap,  0);
        chk("rst_full",  f_count, 0);

        reset_n = 1'b1;
        load    = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("up_count", a_count, i % 10);
            chk("up_wrap",  a_wrap,  (i == 10) ? 1 : 0);
        end
        chk("up_end_zero", a_zero, 1);

        load = 1'b1; load_data = 8'd2; en = 1'b0;
        step();
        chk("dn_load", a_count, 2);
        load = 1'b0; en = 1'b1; up = 1'b0;
        step();
        chk("dn_c1", a_count, 1); chk("dn_w1", a_wrap, 0);
        step();
        chk("dn_c0", a_count, 0); chk("dn_w0", a_wrap, 0);
        step();
        chk("dn_c9", a_count, 9); chk("dn_w9", a_wrap, 1); chk("dn_max9", a_max, 1);

        load = 1'b1; load_data = 8'd8; en = 1'b0;
        step();
        chk("sat_load", s_count, 8);
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        chk("sat_c1", s_count, 9); chk("sat_w1", s_wrap, 0);
        step();
        chk("sat_c2", s_count, 9); chk("sat_w2", s_wrap, 1);
        step();
        chk("sat_c3", s_count, 9); chk("sat_w3", s_wrap, 1);
        chk("wrap_mode_c3", a_count, 1);
        load = 1'b1; load_data = 8'd0; en = 1'b0;
        step();
        chk("sat_load0", s_count, 0); chk("sat_load0_w", s_wrap, 0);
        load = 1'b0; en = 1'b1; up = 1'b0;
        step();
        chk("sat_dn_c", s_count, 0); chk("sat_dn_w", s_wrap, 1);

        load = 1'b1; load_data = 8'd13; en = 1'b0;
        step();
        chk("clamp", a_count, 9); chk("clamp_max", a_max, 1);
        chk("noclamp_full", f_count, 13);
        clear = 1'b1; load_data = 8'd5;
        step();
        chk("clr_over_load", a_count, 0); chk("clr_zero", a_zero, 1);
        clear = 1'b0; en = 1'b1; up = 1'b1;
        step();
        chk("load_over_en", a_count, 5); chk("load_over_en_w", a_wrap, 0);

        load_data = 8'd255; en = 1'b0;
        step();
        chk("full_load", f_count, 255); chk("full_load_max", f_max, 1);
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        chk("full_up_c", f_count, 0); chk("full_up_w", f_wrap, 1);
        up = 1'b0;
        step();
        chk("full_dn_c", f_count, 255); chk("full_dn_w", f_wrap, 1);
        chk("full_dn_max", f_max, 1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_c", f_count, 255); chk("hold_w", f_wrap, 0);
        end

        load = 1'b1; load_data = 8'd3;
        step();
        chk("mid_load", a_count, 3);
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 4; i <= 9; i++) begin
            step();
            chk("mid_up", a_count, i);
        end
        reset_n = 1'b0;
        step();
        chk("mid_rst_c", a_count, 0); chk("mid_rst_w", a_wrap, 0);
        reset_n = 1'b1; en = 1'b0;
        step();
        chk("post_rst_c", a_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised synchronous up/down counter. It is the general-purpose successor to the fixed 4-bit loadable up-counter, adding configurable width, a programmable modulus, direction control, count enable, synchronous clear, and a wrap-or-saturate mode. It is used wherever the design needs event counting, timeouts or modulo sequencing. All state changes on the rising edge of `clk`.

## Interface
Parameters:
- `WIDTH`, 8: counter width in bits, legal range 2..32.
- `MAX_VAL`, 2**WIDTH-1: terminal value; the count range is 0..MAX_VAL. Must satisfy 1 ≤ MAX_VAL ≤ 2**WIDTH-1.
- `SATURATE`, 0: 0 = wrap at the range ends, 1 = hold at the range ends.

Ports:
- `clk` in 1: clock. One clock domain; all logic is on the rising edge.
- `reset_n` in 1: reset. Synchronous, active-low.
- `clear` in 1: synchronous clear to 0.
- `load` in 1: load `load_data` on this edge.
- `load_data` in WIDTH: value to load.
- `en` in 1: count enable.
- `up` in 1: direction. 1 = increment, 0 = decrement.
- `count` out WIDTH: current count, registered.
- `at_zero` out 1: high when `count` == 0. Combinational decode of the `count` register.
- `at_max` out 1: high when `count` == MAX_VAL. Combinational decode of the `count` register.
- `wrap` out 1: registered one-cycle pulse for a boundary event.

## Operation
- Priority per edge, highest first: `reset_n`=0, then `clear`, then `load`, then `en`, then hold.
- Reset (`reset_n` sampled low): `count`=0 and `wrap`=0. As a result, `at_zero`=1 and `at_max`=0. All other inputs are ignored.
- `clear`=1: `count`=0 and `wrap`=0. This is identical to reset, but it is a functional input.
- `load`=1: `count`=`load_data`. If `load_data` > MAX_VAL, `count`=MAX_VAL (clamp). `wrap`=0. The `en` and `up` inputs are ignored on this edge.
- `en`=1 with `up`=1:
  - If `count` < MAX_VAL: `count`+1.
  - If `count` == MAX_VAL: `count`=0 when SATURATE=0, or stays at MAX_VAL when SATURATE=1. In both cases `wrap`=1.
- `en`=1 with `up`=0:
  - If `count` > 0: `count`-1.
  - If `count` == 0: `count`=MAX_VAL when SATURATE=0, or stays at 0 when SATURATE=1. In both cases `wrap`=1.
- Every other edge: `wrap`=0, so `wrap` is never high for two cycles unless a boundary event occurs on consecutive edges.
- Arithmetic is modulo MAX_VAL+1, computed at WIDTH bits. When MAX_VAL = 2**WIDTH-1, wrap equals natural binary overflow.
- `count` never leaves 0..MAX_VAL under any input sequence.
- Changing `up` between edges is legal and takes effect on the next enabled edge.

## Timing
- Latency from any control input to `count` is 1 cycle: the value sampled at edge N is visible after edge N.
- `wrap` is high for exactly the cycle following the boundary edge, aligned with the new `count` value.
- `at_zero` and `at_max` follow `count` within the same cycle, with no extra latency.
- Asserting reset or `clear` in the middle of a run takes effect on that edge. A `wrap` pending from the same edge is suppressed.
- Simultaneous inputs:
  - `clear` and `load` together: clear wins.
  - `load` and `en` together: load wins, and no count step occurs on that edge.
- There is no handshake; every edge with `en`=1 is one step.

## Test plan
- Reset, with WIDTH=4 and MAX_VAL=9:
  - Stimulus: hold `reset_n`=0 for 2 cycles with `en`=1 and `load`=1.
  - Required response: `count`=0, `at_zero`=1, `wrap`=0.
  - Release reset, then apply 10 up steps. Required response: `count` sequence 1..9 then 0, with a single `wrap` pulse in the cycle `count` returns to 0.
- Down wrap, with WIDTH=4 and MAX_VAL=9:
  - Stimulus: load 2, then apply 3 down steps.
  - Required response: `count` sequence 1, 0, 9. `wrap` is high only with the 9. `at_max`=1 at 9.
- Saturate, with SATURATE=1, WIDTH=4, MAX_VAL=9:
  - Stimulus: load 8, then apply 3 up steps.
  - Required response: `count` sequence 9, 9, 9, with `wrap` high on the 2nd and 3rd steps.
  - Then load 0 and apply 1 down step. Required response: `count`=0 and `wrap`=1.
- Load clamp and priority, with WIDTH=4 and MAX_VAL=9:
  - `load_data`=13 with `load`=1 gives `count`=9.
  - `clear`=1 and `load`=1 with `load_data`=5 gives `count`=0.
  - `load`=1 with `load_data`=5 and `en`=1 gives `count`=5, with no step.
- Full-range default, with WIDTH=8:
  - Stimulus: load 255, then 1 up step.
  - Required response: `count`=0 and `wrap`=1.
  - Then 1 down step. Required response: `count`=255, `wrap`=1, `at_max`=1.
  - With `en`=0 for 5 cycles, `count` holds at 255 and `wrap`=0.
- Mid-run reset:
  - Stimulus: count up from 3, and assert `reset_n`=0 on the edge where a wrap would occur.
  - Required response: `count`=0 and `wrap`=0 after that edge.
